alu32_issue_ctrl: RTL and testbench
===================================

# alu32_issue_ctrl

Request-side controller for the registered 32-bit ALU. Accepts tagged operation requests over a valid/ready handshake, drives the ALU operand and select inputs, and captures each ALU result after the ALU's fixed latency. Results are queued in a small FIFO and returned in order over a second valid/ready handshake. The block sits between any operation source (sequencer, bench driver, bus bridge) and the ALU instance, so the ALU never needs flow control of its own.

## Interface
- `WIDTH`, 32, operand/result width
- `SEL_W`, 4, ALU select width
- `TAG_W`, 4, opaque request tag width
- `LATENCY`, 1, ALU clock edges from input sampling to valid `out`; ≥1
- `DEPTH`, 4, response FIFO depth and maximum outstanding operations; power of two, ≥2

- `clk` in 1, single clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `req_valid` in 1, request present
- `req_ready` out 1, request accepted when both high at an edge
- `req_a`, `req_b` in WIDTH, operands
- `req_sel` in SEL_W, ALU operation select, passed through unmodified
- `req_tag` in TAG_W, returned with the result
- `alu_a`, `alu_b` out WIDTH, registered, to ALU `a`/`b`
- `alu_sel` out SEL_W, registered, to ALU `sel`
- `alu_out` in WIDTH, from ALU `out`
- `rsp_valid` out 1, FIFO non-empty
- `rsp_ready` in 1, response consumed when both high at an edge
- `rsp_result` out WIDTH, FIFO head result
- `rsp_tag` out TAG_W, FIFO head tag
- `inflight` out clog2(DEPTH)+1, operations issued but not yet written to FIFO

## Operation
- Credits: `free = DEPTH − fifo_count − inflight`; `req_ready = (free != 0)`, combinational from registered state only (no path from `req_valid` or `rsp_ready`).
- Accept: on accept, `alu_a/b/sel` load the request at that edge; otherwise they hold their last values. The tag plus a valid bit enter a capture pipeline of LATENCY+1 stages.
- Capture: when the valid bit leaves the pipeline, `alu_out` and the tag are pushed into the FIFO at that edge. A push never finds the FIFO full; credits guarantee it.
- Return: `rsp_*` shows the FIFO head; pop on `rsp_valid && rsp_ready`. Order is strictly request order. Tags are opaque and may repeat or wrap freely.
- Simultaneous accept, capture push and response pop in one cycle are all legal. `fifo_count` and `inflight` each update by their own net change.
- A credit freed by a pop at edge n makes `req_ready` high after edge n.
- `req_sel` is not decoded. Invalid selects pass through unchanged.

## Timing
- Reset (async assert, sync deassert at the source) puts every output in a known state:
  - `alu_a`, `alu_b`, `alu_sel` = 0
  - `rsp_valid` = 0, `rsp_result` = 0, `rsp_tag` = 0
  - `inflight` = 0
  - `req_ready` = 1
- Reset mid-operation discards all in-flight and queued results. No response for any pre-reset request ever appears.
- Latency, with the request accepted at edge k:
  - `alu_*` updates at edge k.
  - The ALU samples at edge k+1.
  - `alu_out` is captured at edge k+1+LATENCY.
  - `rsp_valid` goes high after that edge: 2 cycles after accept for LATENCY=1.
- Throughput is one op per cycle, sustained, when `rsp_ready`=1 and DEPTH ≥ LATENCY+2. Otherwise it is limited by credits.
- Full case: DEPTH outstanding with `rsp_ready`=0 drives `req_ready`=0. No loss, no duplication.
- Empty case: `rsp_valid`=0. `rsp_ready` is ignored.

## Structure
- Shared package `alu32_pkg` holds:
  - `WIDTH` and `SEL_W` constants, shared with the ALU
  - a `alu32_rsp_t` typedef of {result, tag}, the FIFO entry
- One sub-module: `alu32_rsp_fifo`, a synchronous FIFO of `alu32_rsp_t`, DEPTH entries. It has push/pop/count ports and a head visible combinationally, and resets to empty on `rst_n`.
- The credit counter and the capture pipeline live in the top module.

## Test plan
Benches use a stub ALU that registers `out = a + b` on each edge (LATENCY=1). Default DEPTH=4.
- Reset: hold `rst_n`=0 → `req_ready`=1, `rsp_valid`=0, `alu_a/b/sel`=0, `inflight`=0.
- Single op: a=1, b=1, sel=0000, tag=3 accepted at edge 0 → `alu_a`=1 after edge 0; `rsp_valid`=1 after edge 2 with result 32'h2, tag 3; `inflight` 1→0.
- Streaming: 8 ops (a=i, b=1, tags 0..7) with `rsp_ready`=1 → `req_ready` never drops; results i+1 in tag order, one per cycle.
- Backpressure: `rsp_ready`=0 with continuous requests → exactly 4 accepts, then `req_ready`=0. Raise `rsp_ready` → 4 in-order responses; `req_ready` returns 1 the cycle after the first pop.
- Boundary: FIFO full, pop and new accept on the same edge → count stays consistent; 5th result delivered correctly; no overflow.
- Reset mid-flight: 2 ops in flight plus 1 queued, pulse `rst_n` low → `rsp_valid` stays 0 afterwards until a new request; the next op (tag 9) returns tag 9 first.

Source files
------------

// File: rtl/alu32_pkg.sv
// Constants and the response-FIFO entry type shared by the ALU, its issue
// controller and the controller's response FIFO.
package alu32_pkg;

  localparam int WIDTH = 32;
  localparam int SEL_W = 4;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag;
  } alu32_rsp_t;

endpackage

// File: rtl/alu32_issue_ctrl_if.sv
// Request and response handshakes between an operation source (master) and
// the ALU issue controller (slave).
interface alu32_issue_ctrl_if;
  import alu32_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [SEL_W-1:0] req_sel;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_sel, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_tag
  );

endinterface

// File: rtl/alu32_rsp_fifo.sv
// In-order response FIFO of {result, tag}; head is visible combinationally
// and reads as zero while the FIFO is empty.
module alu32_rsp_fifo
  import alu32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  alu32_rsp_t             push_data_i,
  input  logic                   pop_i,
  output alu32_rsp_t             head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  alu32_rsp_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            pop_ok;

  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_i) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/alu32_issue_ctrl.sv
// Issue controller for the registered 32-bit ALU: credit-based request accept,
// fixed-latency result capture and in-order tagged response return.
module alu32_issue_ctrl
  import alu32_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu32_issue_ctrl_if.slave      bus,
  output logic [WIDTH-1:0]       alu_a_o,
  output logic [WIDTH-1:0]       alu_b_o,
  output logic [SEL_W-1:0]       alu_sel_o,
  input  logic [WIDTH-1:0]       alu_out_i,
  output logic [$clog2(DEPTH):0] inflight_o
);

  localparam int STAGES = LATENCY + 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic             accept, push, pop, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W:0]   occupancy;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic [STAGES-1:0] vld_q;
  logic [TAG_W-1:0] tag_q [STAGES];
  alu32_rsp_t       push_data, head;

  // Credits depend on registered state only, so req_ready never sees req_valid.
  assign occupancy     = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign bus.req_ready = (occupancy < (CNT_W+1)'(DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign push          = vld_q[STAGES-1];
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  always_comb begin
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(push);
    if (accept) begin
      alu_a_d   = bus.req_a;
      alu_b_d   = bus.req_b;
      alu_sel_d = bus.req_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      inflight_q <= '0;
    end else begin
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      inflight_q <= inflight_d;
    end
  end

  // Stage 0 mirrors the ALU input registers; the last stage lines up with a
  // valid alu_out, LATENCY edges after the ALU samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q    <= {vld_q[STAGES-2:0], accept};
      tag_q[0] <= bus.req_tag;
      for (int i = 1; i < STAGES; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    push_data.result = alu_out_i;
    push_data.tag    = tag_q[STAGES-1];
  end

  alu32_rsp_fifo #(
    .DEPTH(DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign bus.rsp_valid  = !fifo_empty;
  assign bus.rsp_result = head.result;
  assign bus.rsp_tag    = head.tag;

  assign alu_a_o    = alu_a_q;
  assign alu_b_o    = alu_b_q;
  assign alu_sel_o  = alu_sel_q;
  assign inflight_o = inflight_q;

endmodule

// File: tb/tb_alu32_issue_ctrl.sv
// Directed bench for alu32_issue_ctrl driving a stub ALU (out <= a + b, one
// edge of latency) with an in-order expected-response queue.
module tb_alu32_issue_ctrl;
  import alu32_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu32_issue_ctrl_if bus ();

  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [SEL_W-1:0] alu_sel;
  logic [2:0]       inflight;

  alu32_issue_ctrl #(
    .LATENCY(1),
    .DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_sel_o  (alu_sel),
    .alu_out_i  (alu_out),
    .inflight_o (inflight)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_out <= '0;
    else        alu_out <= alu_a + alu_b;
  end

  int checks = 0;
  int failures = 0;
  int n_acc = 0;
  int n_rsp = 0;
  alu32_rsp_t exp_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] sel, input logic [3:0] tag);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sel   = sel;
    bus.req_tag   = tag;
  endtask

  // Observe the handshakes that will complete at the coming edge, then advance.
  task automatic step();
    alu32_rsp_t e;
    if (bus.req_valid && bus.req_ready) begin
      e.result = bus.req_a + bus.req_b;
      e.tag    = bus.req_tag;
      exp_q.push_back(e);
      n_acc++;
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", bus.rsp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_result", bus.rsp_result, e.result);
        check("rsp_tag", bus.rsp_tag, e.tag);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r0, n;
    logic [3:0] sel_c;

    drive(0, 0, 0, 0, 0);
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_tag", bus.rsp_tag, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_inflight", inflight, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single op, a=1 b=1 tag=3
    drive(1, 1, 1, 4'h0, 4'h3);
    check("single_ready", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    check("single_alu_a", alu_a, 1);
    check("single_alu_b", alu_b, 1);
    check("single_alu_sel", alu_sel, 0);
    check("single_inflight_1", inflight, 1);
    check("single_valid_e0", bus.rsp_valid, 0);
    step();
    check("single_valid_e1", bus.rsp_valid, 0);
    check("single_inflight_e1", inflight, 1);
    step();
    check("single_valid_e2", bus.rsp_valid, 1);
    check("single_result", bus.rsp_result, 32'h2);
    check("single_tag", bus.rsp_tag, 3);
    check("single_inflight_0", inflight, 0);
    bus.rsp_ready = 1'b1;
    step();
    check("single_popped", bus.rsp_valid, 0);

    // streaming 8 ops, invalid selects pass straight through
    r0 = n_rsp;
    for (int c = 0; c < 10; c++) begin
      sel_c = 4'(c) ^ 4'hF;
      if (c < 8) begin
        drive(1, c, 1, sel_c, 4'(c));
        check("stream_ready", bus.req_ready, 1);
      end else begin
        bus.req_valid = 1'b0;
      end
      step();
      if (c < 8) begin
        check("stream_alu_a", alu_a, c);
        check("stream_alu_sel", alu_sel, sel_c);
      end
      if (c >= 2) check("stream_rsp_valid", bus.rsp_valid, 1);
    end
    step();
    check("stream_count", n_rsp - r0, 8);
    check("stream_empty", bus.rsp_valid, 0);

    // backpressure: only DEPTH accepts while responses are held
    bus.rsp_ready = 1'b0;
    a0 = n_acc;
    r0 = n_rsp;
    for (int c = 0; c < 8; c++) begin
      n = n_acc - a0;
      drive(1, 32'h1000 + n, n, 4'h1, 4'(n + 8));
      step();
    end
    check("bp_accepts", n_acc - a0, 4);
    check("bp_ready_low", bus.req_ready, 0);
    check("bp_inflight", inflight, 0);
    check("bp_rsp_valid", bus.rsp_valid, 1);
    check("bp_head", bus.rsp_result, 32'h1000);
    bus.rsp_ready = 1'b1;
    step();
    check("bp_ready_after_pop", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    check("bd_accepts", n_acc - a0, 5);
    check("bd_inflight", inflight, 1);
    check("bd_ready", bus.req_ready, 1);
    drain(20);
    check("bd_rsp_count", n_rsp - r0, 5);
    check("bd_empty", bus.rsp_valid, 0);

    // reset with two in flight and one queued
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 10 + k, k, 4'h2, 4'(k + 12));
      step();
    end
    bus.req_valid = 1'b0;
    check("mid_inflight", inflight, 2);
    check("mid_rsp_valid", bus.rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.rsp_valid, 0);
    check("mid_rst_inflight", inflight, 0);
    check("mid_rst_ready", bus.req_ready, 1);
    check("mid_rst_tag", bus.rsp_tag, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("post_rst_quiet", bus.rsp_valid, 0);
    end
    drive(1, 5, 6, 4'h0, 4'h9);
    step();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 10 && !bus.rsp_valid; k++) begin
      @(posedge clk);
      #1;
    end
    check("post_rst_valid", bus.rsp_valid, 1);
    check("post_rst_tag", bus.rsp_tag, 9);
    check("post_rst_result", bus.rsp_result, 11);
    drain(10);
    step();
    check("post_rst_empty", bus.rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
